line_slot_ctrl: RTL

- Controller that owns NUM_SLOTS line_sprite engines and sequences their endpoint configuration.
- A host writes segment endpoints into per-slot shadow registers through a valid/ready port.
- At each frame boundary the dirty shadow entries are committed to the active endpoint outputs. The controller then holds the engines in reset for PRIME_CYCLES so their Bresenham state and registered min/max re-initialise, and only then raises each slot's line_active.
- Sits between the host/gesture logic and the bank of line_sprite instances in the video pipeline.

---
 rtl/line_ctrl_pkg.sv | 22 ++
 rtl/line_slot_reg.sv | 52 +++++
 rtl/line_slot_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/line_ctrl_pkg.sv
// Shared types for the line_slot_ctrl controller: endpoint widths, segment record
// and controller FSM states.
package line_ctrl_pkg;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    typedef struct packed {
        logic [X_W-1:0] x1;
        logic [Y_W-1:0] y1;
        logic [X_W-1:0] x2;
        logic [Y_W-1:0] y2;
        logic           enable;
    } segment_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        COMMIT = 2'd1,
        PRIME  = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/line_slot_reg.sv
// One line-engine slot: host-facing shadow segment, engine-facing active segment
// and a dirty flag marking shadow contents not yet committed.
module line_slot_reg
    import line_ctrl_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     wr_en_i,
    input  segment_t wr_seg_i,
    input  logic     commit_i,
    output segment_t active_o
);

    segment_t shadow_q, shadow_d;
    segment_t active_q, active_d;
    logic     dirty_q, dirty_d;

    // Next-state: a write issued alongside a commit re-marks the slot dirty.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        dirty_d  = dirty_q;
        if (commit_i && dirty_q) begin
            active_d = shadow_q;
            dirty_d  = 1'b0;
        end else begin
            active_d = active_q;
        end
        if (wr_en_i) begin
            shadow_d = wr_seg_i;
            dirty_d  = 1'b1;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Slot storage registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q <= '0;
            active_q <= '0;
            dirty_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            dirty_q  <= dirty_d;
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/line_slot_ctrl.sv
// Owns NUM_SLOTS line engines: buffers host endpoint writes, commits them at frame
// boundaries and holds the engines in reset for PRIME_CYCLES before re-enabling them.
module line_slot_ctrl
    import line_ctrl_pkg::*;
#(
    parameter int NUM_SLOTS    = 4,
    parameter int SLOT_W       = 2,
    parameter int PRIME_CYCLES = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     new_frame_in,
    input  logic                     wr_valid_in,
    output logic                     wr_ready_out,
    input  logic [SLOT_W-1:0]        wr_slot_in,
    input  logic [X_W-1:0]           wr_x1_in,
    input  logic [X_W-1:0]           wr_x2_in,
    input  logic [Y_W-1:0]           wr_y1_in,
    input  logic [Y_W-1:0]           wr_y2_in,
    input  logic                     wr_enable_in,
    output logic [NUM_SLOTS*X_W-1:0] x1_out,
    output logic [NUM_SLOTS*X_W-1:0] x2_out,
    output logic [NUM_SLOTS*Y_W-1:0] y1_out,
    output logic [NUM_SLOTS*Y_W-1:0] y2_out,
    output logic [NUM_SLOTS-1:0]     line_active_out,
    output logic                     sprite_rst_out,
    output logic                     commit_done_out,
    output logic                     wr_err_out
);

    localparam int               CNT_W    = $clog2(PRIME_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRIME_CYCLES - 1);

    ctrl_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pending_q, pending_d;
    logic                 primed_q, primed_d;
    logic                 wr_ready_q, wr_ready_d;
    logic                 sprite_rst_q, sprite_rst_d;
    logic [NUM_SLOTS-1:0] line_active_q, line_active_d;
    logic                 commit_done_q, commit_done_d;
    logic                 wr_err_q, wr_err_d;

    logic                 wr_accept_s;
    logic                 slot_ok_s;
    logic                 commit_s;
    segment_t             wr_seg_s;
    segment_t             active_seg_s [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] active_en_s;

    assign wr_accept_s = wr_valid_in & wr_ready_q;
    assign slot_ok_s   = (32'(wr_slot_in) < 32'(NUM_SLOTS));
    assign commit_s    = (state_q == COMMIT);
    assign wr_seg_s    = '{x1: wr_x1_in, y1: wr_y1_in, x2: wr_x2_in, y2: wr_y2_in,
                           enable: wr_enable_in};

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        line_slot_reg u_slot (
            .clk_i    (clk_in),
            .rst_i    (rst_in),
            .wr_en_i  (wr_accept_s && slot_ok_s && (wr_slot_in == SLOT_W'(g))),
            .wr_seg_i (wr_seg_s),
            .commit_i (commit_s),
            .active_o (active_seg_s[g])
        );
        assign active_en_s[g]          = active_seg_s[g].enable;
        assign x1_out[g*X_W +: X_W]    = active_seg_s[g].x1;
        assign x2_out[g*X_W +: X_W]    = active_seg_s[g].x2;
        assign y1_out[g*Y_W +: Y_W]    = active_seg_s[g].y1;
        assign y2_out[g*Y_W +: Y_W]    = active_seg_s[g].y2;
    end

    // FSM next-state; a frame pulse during COMMIT/PRIME queues exactly one more commit.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pending_d     = pending_q;
        primed_d      = primed_q;
        commit_done_d = 1'b0;
        case (state_q)
            RUN: begin
                if (new_frame_in || pending_q) begin
                    state_d = COMMIT;
                end else begin
                    state_d = RUN;
                end
            end
            COMMIT: begin
                state_d   = PRIME;
                cnt_d     = '0;
                pending_d = new_frame_in;
                primed_d  = 1'b1;
            end
            PRIME: begin
                pending_d = pending_q | new_frame_in;
                if (cnt_q == CNT_LAST) begin
                    state_d       = RUN;
                    cnt_d         = '0;
                    commit_done_d = primed_q;
                    primed_d      = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = PRIME;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        wr_ready_d    = (state_d != COMMIT);
        sprite_rst_d  = (state_d == PRIME);
        line_active_d = '0;
        if (state_d == RUN) begin
            line_active_d = active_en_s;
        end else begin
            line_active_d = '0;
        end
        wr_err_d = wr_err_q | (wr_accept_s & ~slot_ok_s);
    end

    // Controller state and output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= PRIME;
            cnt_q         <= '0;
            pending_q     <= 1'b0;
            primed_q      <= 1'b0;
            wr_ready_q    <= 1'b0;
            sprite_rst_q  <= 1'b1;
            line_active_q <= '0;
            commit_done_q <= 1'b0;
            wr_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            primed_q      <= primed_d;
            wr_ready_q    <= wr_ready_d;
            sprite_rst_q  <= sprite_rst_d;
            line_active_q <= line_active_d;
            commit_done_q <= commit_done_d;
            wr_err_q      <= wr_err_d;
        end
    end

    assign wr_ready_out    = wr_ready_q;
    assign sprite_rst_out  = sprite_rst_q;
    assign line_active_out = line_active_q;
    assign commit_done_out = commit_done_q;
    assign wr_err_out      = wr_err_q;

endmodule
